// File: rtl/rf_access_arbiter.sv
// rtl/rf_access_arbiter.sv - two-requester round-robin register-file access arbiter
//
// Purpose: serialises register-file accesses from a core (A) and a debug (B)
// requester. Each transaction takes three cycles: IDLE (capture), ACCESS
// (register-file strobe and grant) and RESP (response pulse). At most one
// transaction is in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_/b_valid, a_/b_we           request pending, 1 = write / 0 = read
//   a_/b_addr1, a_/b_addr2        write or first read address, second read address
//   a_/b_wdata                    write data
//   a_/b_gnt                      grant pulse (ACCESS cycle)
//   a_/b_rsp_valid                response pulse (RESP cycle)
//   rsp_rd1, rsp_rd2              response read data, shared, held outside RESP
//   rf_we, rf_re                  register-file write / read enables
//   rf_waddr, rf_raddr            port 1 / write address, port 2 address
//   rf_wdata                      register-file write data
//   rf_rd1, rf_rd2                register-file read data
//
// Configuration macro: RF_ARB_X0_GUARD_EN - when defined, address 0 behaves as
// a hardwired zero register (writes suppressed, reads return 0).
module rf_access_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr1,
    input  logic [AW-1:0] a_addr2,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_valid,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr1,
    input  logic [AW-1:0] b_addr2,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rsp_valid,
    output logic          b_rsp_valid,
    output logic [DW-1:0] rsp_rd1,
    output logic [DW-1:0] rsp_rd2,
    output logic          rf_we,
    output logic          rf_re,
    output logic [AW-1:0] rf_waddr,
    output logic [AW-1:0] rf_raddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2
);

`ifdef RF_ARB_X0_GUARD_EN
    localparam bit X0_GUARD = 1'b1;
`else
    localparam bit X0_GUARD = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;      // 0 = A owns the transaction, 1 = B
    logic          ptr_q, ptr_d;      // round-robin preference on a tie, 0 = A
    logic          we_q, we_d;
    logic [AW-1:0] addr1_q, addr1_d;
    logic [AW-1:0] addr2_q, addr2_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;

    logic in_access;
    logic in_resp;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        wdata_d = wdata_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    // On a tie the pointer picks the winner and then moves to
                    // the loser; a lone requester leaves the pointer alone.
                    if (a_valid && b_valid) begin
                        win_d = ptr_q;
                        ptr_d = ~ptr_q;
                    end else begin
                        win_d = b_valid;
                    end
                    we_d    = win_d ? b_we    : a_we;
                    addr1_d = win_d ? b_addr1 : a_addr1;
                    addr2_d = win_d ? b_addr2 : a_addr2;
                    wdata_d = win_d ? b_wdata : a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Read data is captured here so it stays stable for the whole
                // RESP cycle and afterwards, independent of the register file.
                if (we_q) begin
                    rd1_d = '0;
                    rd2_d = '0;
                end else begin
                    rd1_d = (X0_GUARD && (addr1_q == '0)) ? '0 : rf_rd1;
                    rd2_d = (X0_GUARD && (addr2_q == '0)) ? '0 : rf_rd2;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            wdata_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            wdata_q <= wdata_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    // All strobes decode from registered state only, so nothing toggles
    // combinationally with the requester inputs.
    assign in_access   = (state_q == ACCESS);
    assign in_resp     = (state_q == RESP);
    assign a_gnt       = in_access && !win_q;
    assign b_gnt       = in_access &&  win_q;
    assign a_rsp_valid = in_resp   && !win_q;
    assign b_rsp_valid = in_resp   &&  win_q;
    assign rf_we       = in_access &&  we_q && !(X0_GUARD && (addr1_q == '0));
    assign rf_re       = in_access && !we_q;
    assign rf_waddr    = in_access ? addr1_q : '0;
    assign rf_raddr    = (in_access && !we_q) ? addr2_q : '0;
    assign rf_wdata    = (in_access &&  we_q) ? wdata_q : '0;
    assign rsp_rd1     = rd1_q;
    assign rsp_rd2     = rd2_q;

endmodule
